// File: rtl/cskip_adder_pipe_if.sv
// Operand/result handshake bundle for cskip_adder_pipe.
// Define CSKIP_OVF_EN to add the signed-overflow result bit (ovf).
interface cskip_adder_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSKIP_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor: one WIDTH/STAGES slice per stage, valid/ready on both ends.
// Define CSKIP_OVF_EN to also produce the pipelined signed-overflow flag.
module cskip_adder_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int BLOCK  = 4
) (
  input logic              clk,
  input logic              rst,
  cskip_adder_pipe_if.slave bus
);

  localparam int SW = WIDTH / STAGES;
  localparam int NB = SW / BLOCK;
`ifdef CSKIP_OVF_EN
  localparam int RW = SW + 2;
`else
  localparam int RW = SW + 1;
`endif

  // Returns {[carry into slice MSB,] carry-out, sum}; ripple inside a block, skip mux across it.
  function automatic logic [RW-1:0] slice_add(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
    logic [SW-1:0] s;
    logic          c;
    logic          rc;
    logic          p;
    logic          t;
    int            n;
`ifdef CSKIP_OVF_EN
    logic          cm;
    cm = ci;
`endif
    s = '0;
    c = ci;
    for (int j = 0; j < NB; j++) begin
      p  = 1'b1;
      rc = c;
      for (int i = 0; i < BLOCK; i++) begin
        n = j * BLOCK + i;
        t = x[n] ^ y[n];
`ifdef CSKIP_OVF_EN
        if (n == SW - 1) cm = rc;
`endif
        s[n] = t ^ rc;
        rc   = (x[n] & y[n]) | (rc & t);
        p    = p & t;
      end
      c = p ? c : rc;
    end
`ifdef CSKIP_OVF_EN
    return {cm, c, s};
`else
    return {c, s};
`endif
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] cin_k;
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] nxt_c;
  logic [WIDTH-1:0]  s_r   [STAGES];
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];
  logic [WIDTH-1:0]  op_a  [STAGES];
  logic [WIDTH-1:0]  op_b  [STAGES];
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [RW-1:0]     res   [STAGES];
`ifdef CSKIP_OVF_EN
  logic              ovf_r;
`endif

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = !v[STAGES-1] || bus.out_ready;
    adv[STAGES-1] = chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain  = !v[k] || chain;
      adv[k] = chain;
    end
  end

  // Stage 0 takes the raw beat (b inverted, carry forced to 1 for subtract); later stages take the previous register.
  always_comb begin
    op_a[0]  = bus.a;
    op_b[0]  = bus.sub ? ~bus.b : bus.b;
    cin_k[0] = bus.sub | bus.cin;
    src_v[0] = bus.in_valid;
    nxt_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      op_a[k]  = a_r[k-1];
      op_b[k]  = b_r[k-1];
      cin_k[k] = c_r[k-1];
      src_v[k] = v[k-1];
      nxt_s[k] = s_r[k-1];
    end
    nxt_c = '0;
    for (int k = 0; k < STAGES; k++) begin
      res[k]               = slice_add(op_a[k][k*SW +: SW], op_b[k][k*SW +: SW], cin_k[k]);
      nxt_s[k][k*SW +: SW] = res[k][SW-1:0];
      nxt_c[k]             = res[k][SW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v   <= '0;
      c_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        s_r[k] <= '0;
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
`ifdef CSKIP_OVF_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) begin
            s_r[k] <= nxt_s[k];
            c_r[k] <= nxt_c[k];
            a_r[k] <= op_a[k];
            b_r[k] <= op_b[k];
          end
        end
      end
`ifdef CSKIP_OVF_EN
      if (adv[STAGES-1] && src_v[STAGES-1])
        ovf_r <= res[STAGES-1][SW+1] ^ res[STAGES-1][SW];
`endif
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.sum       = s_r[STAGES-1];
  assign bus.cout      = c_r[STAGES-1];
`ifdef CSKIP_OVF_EN
  assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Directed bench for cskip_adder_pipe: vector table, back-to-back, back-pressure and mid-stream reset.
// Checks ovf as well when built with CSKIP_OVF_EN.
module tb_cskip_adder_pipe;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;
  localparam int BLOCK  = 4;
  localparam int NVEC   = 11;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NVEC];

  cskip_adder_pipe_if #(.WIDTH(WIDTH)) bus ();

  cskip_adder_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES),
    .BLOCK (BLOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until the accept edge; returns at edge+1.
  task automatic applyStimulus(input vec_t vec);
    int waitCyc;
    bus.in_valid = 1'b1;
    bus.a        = vec.a;
    bus.b        = vec.b;
    bus.cin      = vec.cin;
    bus.sub      = vec.sub;
    #1;
    waitCyc = 0;
    while (bus.in_ready !== 1'b1 && waitCyc < 50) begin
      @(posedge clk);
      #1;
      waitCyc++;
    end
    if (waitCyc >= 50) checkOutput("accept wait", 64'(waitCyc), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result of a beat accepted on the previous edge and compare it.
  task automatic waitResult(input string name, input vec_t vec);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, " latency"}, 64'(lat), 64'(STAGES - 1));
    checkOutput({name, " sum"}, bus.sum, vec.sum);
    checkOutput({name, " cout"}, 64'(bus.cout), 64'(vec.cout));
`ifdef CSKIP_OVF_EN
    checkOutput({name, " ovf"}, 64'(bus.ovf), 64'(vec.ovf));
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        bb [3];
    vec_t        bp [6];
    vec_t        one;
    logic [63:0] held;
    logic        rdy;
    int          idx;
    int          nrecv;
    int          spurious;

    vecs[0]  = '{64'd998, 64'd128, 1'b0, 1'b0, 64'd1126, 1'b0, 1'b0};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[2]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3]  = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
    vecs[4]  = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
    vecs[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
    vecs[6]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[7]  = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[8]  = '{64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 64'h1E1E_1E1E_1E1E_1E1E, 1'b0, 1'b0};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[10] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    #1 rst = 1'b1;
    #2;
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset sum", bus.sum, 64'd0);
    checkOutput("reset cout", 64'(bus.cout), 64'd0);
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      waitResult($sformatf("vec%0d", i), vecs[i]);
    end

    $display("[TB] back-to-back beats");
    bb[0] = '{64'd998, 64'd128, 1'b0, 1'b0, 64'd1126, 1'b0, 1'b0};
    bb[1] = '{64'd9998, 64'd9028, 1'b0, 1'b0, 64'd19026, 1'b0, 1'b0};
    bb[2] = '{64'd999909989998, 64'd769028, 1'b0, 1'b0, 64'd999910759026, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = bb[i].a;
      bus.b        = bb[i].b;
      bus.cin      = bb[i].cin;
      bus.sub      = bb[i].sub;
      #1;
      checkOutput($sformatf("b2b in_ready%0d", i), 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b out_valid%0d", i), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("b2b sum%0d", i), bus.sum, bb[i].sum);
    end
    @(posedge clk);
    #1;
    checkOutput("b2b drained", 64'(bus.out_valid), 64'd0);

    $display("[TB] back-pressure");
    for (int i = 0; i < 6; i++)
      bp[i] = '{64'(100 * (i + 1)), 64'(i), 1'b0, 1'b0, 64'(100 * (i + 1) + i), 1'b0, 1'b0};
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1;
      bus.a        = bp[idx].a;
      bus.b        = bp[idx].b;
      bus.cin      = 1'b0;
      bus.sub      = 1'b0;
      #1;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) idx++;
      #1;
    end
    checkOutput("bp accepted", 64'(idx), 64'd4);
    checkOutput("bp full in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("bp head valid", 64'(bus.out_valid), 64'd1);
    checkOutput("bp head sum", bus.sum, bp[0].sum);
    held = bus.sum;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp stable sum", bus.sum, held);
    checkOutput("bp stable valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp accept+drain in_ready", 64'(bus.in_ready), 64'd1);
    nrecv = 0;
    for (int c = 0; c < 15; c++) begin
      if (idx < 6) begin
        bus.in_valid = 1'b1;
        bus.a        = bp[idx].a;
        bus.b        = bp[idx].b;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      rdy = bus.in_ready;
      if (bus.out_valid === 1'b1) begin
        if (nrecv < 6) checkOutput($sformatf("bp order%0d", nrecv), bus.sum, bp[nrecv].sum);
        nrecv++;
      end
      @(posedge clk);
      if (rdy && idx < 6) idx++;
      #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("bp all accepted", 64'(idx), 64'd6);
    checkOutput("bp results count", 64'(nrecv), 64'd6);

    $display("[TB] reset mid-stream");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 64'(11 * (i + 1));
      bus.b        = 64'd0;
      bus.cin      = 1'b0;
      bus.sub      = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre-reset valid", 64'(bus.out_valid), 64'd1);
    checkOutput("pre-reset sum", bus.sum, 64'd11);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async reset sum", bus.sum, 64'd0);
    checkOutput("async reset cout", 64'(bus.cout), 64'd0);
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    spurious = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) spurious++;
    end
    checkOutput("no stale results", 64'(spurious), 64'd0);
    one = '{64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0};
    applyStimulus(one);
    waitResult("post-reset beat", one);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
